// File: rtl/uart_transmitter.sv
// ----------------------------------------------------------------------------
// uart_transmitter
//
// Purpose:
//    Serialises 8-bit bytes onto a single-wire UART line. A frame is one start
//    bit (0), eight data bits LSB first, an optional even-parity bit, then
//    STOP_BITS stop bits (1). The line idles high. Bytes arrive over a
//    valid/ready handshake that completes only in IDLE, so nothing is queued.
//    Back-to-back frames are always separated by at least one IDLE cycle.
//
// Parameters:
//    CLKS_PER_BIT - clk_in cycles per line bit, 1..65535
//    STOP_BITS    - number of stop bits, 1 or 2
//
// Ports:
//    clk_in   in   1  clock; all state changes on its rising edge
//    reset    in   1  synchronous active-low reset
//    tx_data  in   8  byte to send, sampled on the acceptance edge only
//    tx_valid in   1  upstream has a byte ready
//    tx_ready out  1  high only in IDLE; transfer when tx_valid && tx_ready
//    data_out out  1  registered serial line, idles high
//    busy     out  1  high from acceptance until the return to IDLE
//
// Build option:
//    UART_TX_PARITY_EN - when defined, an even-parity bit (XOR of the byte)
//                        is sent between the last data bit and the stop bits.
// ----------------------------------------------------------------------------
module uart_transmitter #(
   parameter int CLKS_PER_BIT = 1,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk_in,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       data_out,
   output logic       busy
);

   // Reject illegal parameter values at elaboration time.
   generate
      if ((CLKS_PER_BIT < 1) || (CLKS_PER_BIT > 65535)) begin : g_bad_clks_per_bit
         $error("uart_transmitter: CLKS_PER_BIT must be in 1..65535");
      end
      if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
         $error("uart_transmitter: STOP_BITS must be 1 or 2");
      end
   endgenerate

   // Last baud-counter value of a bit and last stop-bit index.
   localparam logic [15:0] LP_BAUD_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [2:0]  LP_STOP_LAST = 3'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } state_t;

   state_t      r_state;
   logic [15:0] r_baud_cnt;
   logic [2:0]  r_bit_cnt;
   logic [7:0]  r_shift;
   logic        r_data_out;
   logic        r_tx_ready;
   logic        r_busy;
`ifdef UART_TX_PARITY_EN
   logic        r_parity;

   // Even parity: the bit that makes the total number of ones even.
   function automatic logic even_parity(input logic [7:0] i_byte);
      return ^i_byte;
   endfunction
`endif

   logic w_accept;
   logic w_bit_end;

   assign w_accept  = tx_valid & r_tx_ready;
   assign w_bit_end = (r_baud_cnt == LP_BAUD_LAST);

   // Transmit FSM: state, counters, shift register and all registered outputs.
   always_ff @(posedge clk_in) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_baud_cnt <= 16'd0;
         r_bit_cnt  <= 3'd0;
         r_shift    <= 8'h00;
         r_data_out <= 1'b1;
         r_tx_ready <= 1'b1;
         r_busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_parity   <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_shift    <= tx_data;
                  r_baud_cnt <= 16'd0;
                  r_bit_cnt  <= 3'd0;
                  r_data_out <= 1'b0;
                  r_tx_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= ST_START;
`ifdef UART_TX_PARITY_EN
                  r_parity   <= even_parity(tx_data);
`endif
               end else begin
                  r_data_out <= 1'b1;
                  r_tx_ready <= 1'b1;
                  r_busy     <= 1'b0;
               end
            end

            ST_START: begin
               if (w_bit_end) begin
                  r_baud_cnt <= 16'd0;
                  r_data_out <= r_shift[0];
                  r_state    <= ST_DATA;
               end else begin
                  r_baud_cnt <= r_baud_cnt + 16'd1;
               end
            end

            ST_DATA: begin
               if (w_bit_end) begin
                  r_baud_cnt <= 16'd0;
                  r_shift    <= {1'b0, r_shift[7:1]};
                  // The counter wraps 7 -> 0, ready for reuse as stop-bit index.
                  r_bit_cnt  <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     r_data_out <= r_parity;
                     r_state    <= ST_PARITY;
`else
                     r_data_out <= 1'b1;
                     r_state    <= ST_STOP;
`endif
                  end else begin
                     // shift[1] becomes shift[0] on this same edge.
                     r_data_out <= r_shift[1];
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + 16'd1;
               end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (w_bit_end) begin
                  r_baud_cnt <= 16'd0;
                  r_bit_cnt  <= 3'd0;
                  r_data_out <= 1'b1;
                  r_state    <= ST_STOP;
               end else begin
                  r_baud_cnt <= r_baud_cnt + 16'd1;
               end
            end
`endif

            ST_STOP: begin
               r_data_out <= 1'b1;
               if (w_bit_end) begin
                  r_baud_cnt <= 16'd0;
                  if (r_bit_cnt == LP_STOP_LAST) begin
                     r_bit_cnt  <= 3'd0;
                     r_tx_ready <= 1'b1;
                     r_busy     <= 1'b0;
                     r_state    <= ST_IDLE;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + 16'd1;
               end
            end

            default: begin
               // Unreachable encoding: recover to a quiet, idle line.
               r_state    <= ST_IDLE;
               r_baud_cnt <= 16'd0;
               r_bit_cnt  <= 3'd0;
               r_data_out <= 1'b1;
               r_tx_ready <= 1'b1;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign tx_ready = r_tx_ready;
   assign data_out = r_data_out;
   assign busy     = r_busy;

endmodule

// File: tb/tb_uart_transmitter.sv
// ----------------------------------------------------------------------------
// tb_uart_transmitter
//
// Directed bench for uart_transmitter. Two instances run side by side:
// u_dut1 (CLKS_PER_BIT=1, STOP_BITS=1) and u_dut4 (CLKS_PER_BIT=4,
// STOP_BITS=2). Expected line patterns are hand-written strings, one
// character per bit period in time order. Inputs change and outputs are
// sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_uart_transmitter;

   logic       clk;
   logic       reset1, reset4;
   logic [7:0] tx_data1, tx_data4;
   logic       tx_valid1, tx_valid4;
   logic       tx_ready1, tx_ready4;
   logic       data_out1, data_out4;
   logic       busy1, busy4;

   int n_tests = 0;
   int n_fail  = 0;
   logic cap [0:63];

`ifdef UART_TX_PARITY_EN
   localparam int    LEN1    = 11;
   localparam string EXP_A5  = "01010010101";
   localparam string EXP_B2B = "00000000001101111111101";
   localparam string EXP_81  = "01000000101";
   localparam string EXP_07  = "01110000011";
   localparam string LVL_3C  = "000111100011";
`else
   localparam int    LEN1    = 10;
   localparam string EXP_A5  = "0101001011";
   localparam string EXP_B2B = "000000000110111111111";
   localparam string EXP_81  = "0100000011";
   localparam string LVL_3C  = "00011110011";
`endif

   uart_transmitter #(.CLKS_PER_BIT(1), .STOP_BITS(1)) u_dut1 (
      .clk_in   (clk),
      .reset    (reset1),
      .tx_data  (tx_data1),
      .tx_valid (tx_valid1),
      .tx_ready (tx_ready1),
      .data_out (data_out1),
      .busy     (busy1)
   );

   uart_transmitter #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u_dut4 (
      .clk_in   (clk),
      .reset    (reset4),
      .tx_data  (tx_data4),
      .tx_valid (tx_valid4),
      .tx_ready (tx_ready4),
      .data_out (data_out4),
      .busy     (busy4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report it when observed differs from expected.
   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Rebuild a byte from captured one-cycle-per-bit samples (start bit at s).
   function automatic logic [7:0] rx_byte(input int s);
      logic [7:0] r;
      for (int k = 0; k < 8; k++) r[k] = cap[s + 1 + k];
      return r;
   endfunction

   // Offer byte b to u_dut1 and compare the line against exp, one char per cycle.
   task automatic send1(input logic [7:0] b, input logic [7:0] b_alt,
                        input string exp, input int drop_at, input string tag);
      tx_data1  = b;
      tx_valid1 = 1'b1;
      for (int i = 0; i < exp.len(); i++) begin
         @(negedge clk);
         if (i == 0) tx_data1 = b_alt;
         if (i == drop_at) tx_valid1 = 1'b0;
         cap[i] = data_out1;
         check_value($sformatf("%s_bit%0d", tag, i), {31'd0, data_out1},
                     (exp[i] == "1") ? 32'd1 : 32'd0);
         if (i == 1) begin
            check_value($sformatf("%s_busy", tag), {31'd0, busy1}, 32'd1);
            check_value($sformatf("%s_ready_low", tag), {31'd0, tx_ready1}, 32'd0);
         end
      end
   endtask

   initial begin
      reset1 = 1'b0; reset4 = 1'b0;
      tx_valid1 = 1'b0; tx_valid4 = 1'b0;
      tx_data1 = 8'h00; tx_data4 = 8'h00;
      @(negedge clk);
      @(negedge clk);
      check_value("rst_line1",  {31'd0, data_out1}, 32'd1);
      check_value("rst_ready1", {31'd0, tx_ready1}, 32'd1);
      check_value("rst_busy1",  {31'd0, busy1},     32'd0);
      check_value("rst_line4",  {31'd0, data_out4}, 32'd1);
      check_value("rst_ready4", {31'd0, tx_ready4}, 32'd1);
      check_value("rst_busy4",  {31'd0, busy4},     32'd0);
      reset1 = 1'b1; reset4 = 1'b1;

      // Idle for 20 cycles with tx_valid low.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check_value($sformatf("idle_line%0d", i),  {31'd0, data_out1}, 32'd1);
         check_value($sformatf("idle_ready%0d", i), {31'd0, tx_ready1}, 32'd1);
         check_value($sformatf("idle_busy%0d", i),  {31'd0, busy1},     32'd0);
      end

      // Single byte 8'hA5 at one clock per bit.
      send1(8'hA5, 8'hA5, EXP_A5, 0, "a5");
      check_value("a5_rx", {24'd0, rx_byte(0)}, {24'd0, 8'hA5});
      @(negedge clk);
      check_value("a5_ready_back", {31'd0, tx_ready1}, 32'd1);
      check_value("a5_busy_off",   {31'd0, busy1},     32'd0);

      // 8'h3C at four clocks per bit with two stop bits.
      tx_data4  = 8'h3C;
      tx_valid4 = 1'b1;
      for (int c = 0; c < LVL_3C.len() * 4; c++) begin
         @(negedge clk);
         if (c == 0) tx_valid4 = 1'b0;
         check_value($sformatf("3c_cyc%0d", c), {31'd0, data_out4},
                     (LVL_3C[c / 4] == "1") ? 32'd1 : 32'd0);
         if (c == LVL_3C.len() * 4 - 1)
            check_value("3c_ready_last", {31'd0, tx_ready4}, 32'd0);
      end
      @(negedge clk);
      check_value("3c_ready_back", {31'd0, tx_ready4}, 32'd1);
      check_value("3c_line_idle",  {31'd0, data_out4}, 32'd1);

      // Back-to-back 8'h00 then 8'hFF with tx_valid held high.
      send1(8'h00, 8'hFF, EXP_B2B, LEN1 + 1, "b2b");
      check_value("b2b_rx0", {24'd0, rx_byte(0)},        {24'd0, 8'h00});
      check_value("b2b_rx1", {24'd0, rx_byte(LEN1 + 1)}, {24'd0, 8'hFF});
      @(negedge clk);
      check_value("b2b_ready_back", {31'd0, tx_ready1}, 32'd1);

      // Reset pulse during data bit 3 of 8'hF0 aborts the frame.
      tx_data1  = 8'hF0;
      tx_valid1 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 0) tx_valid1 = 1'b0;
         check_value($sformatf("f0_bit%0d", i), {31'd0, data_out1}, 32'd0);
      end
      reset1 = 1'b0;
      @(negedge clk);
      reset1 = 1'b1;
      check_value("abort_line",  {31'd0, data_out1}, 32'd1);
      check_value("abort_ready", {31'd0, tx_ready1}, 32'd1);
      check_value("abort_busy",  {31'd0, busy1},     32'd0);
      @(negedge clk);
      check_value("abort_line2",  {31'd0, data_out1}, 32'd1);
      check_value("abort_ready2", {31'd0, tx_ready1}, 32'd1);
      send1(8'h81, 8'h81, EXP_81, 0, "81");
      check_value("81_rx", {24'd0, rx_byte(0)}, {24'd0, 8'h81});
      @(negedge clk);
      check_value("81_ready_back", {31'd0, tx_ready1}, 32'd1);

`ifdef UART_TX_PARITY_EN
      // Odd number of ones gives a parity bit of 1.
      send1(8'h07, 8'h07, EXP_07, 0, "07");
      check_value("07_rx", {24'd0, rx_byte(0)}, {24'd0, 8'h07});
      check_value("07_parity", {31'd0, cap[9]}, 32'd1);
      @(negedge clk);
      check_value("07_ready_back", {31'd0, tx_ready1}, 32'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
